readout_arbiter: RTL

READOUT_ARBITER -- requirements
Module: readout_arbiter

---
 rtl/readout_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/readout_arbiter.sv
// -----------------------------------------------------------------------------
// readout_arbiter
// Collects packets from NUM_CHANNELS independent readout streams into small
// per-channel FIFOs and serialises them onto one valid/ready output port with
// round-robin fairness. Sources have no backpressure, so a push to a full FIFO
// is dropped and recorded in a sticky per-channel overflow flag.
// -----------------------------------------------------------------------------
module readout_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_AW      = 2,
    parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] inIndex,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] inData,
    input  logic [NUM_CHANNELS-1:0]            inValid,
    output logic [ADDR_WIDTH-1:0]              outIndex,
    output logic [DATA_WIDTH-1:0]              outData,
    output logic [CH_W-1:0]                    outChannel,
    output logic                               outValid,
    input  logic                               outReady,
    output logic [NUM_CHANNELS-1:0]            overflow,
    input  logic                               clearOverflow
);

    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam int                EW       = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Per-channel FIFO storage and bookkeeping
    // ---------------------------------------------------------------------
    logic [EW-1:0]           r_mem      [NUM_CHANNELS][DEPTH];
    logic [FIFO_AW-1:0]      r_wr_ptr   [NUM_CHANNELS];
    logic [FIFO_AW-1:0]      r_rd_ptr   [NUM_CHANNELS];
    logic [FIFO_AW:0]        r_count    [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] w_nonempty;
    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_drop;
    logic [NUM_CHANNELS-1:0] w_pop;

    // ---------------------------------------------------------------------
    // Arbitration and output stage
    // ---------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_out_valid;
    logic                    w_free;
    logic                    w_grant_vld;
    logic [CH_W-1:0]         w_grant;
    logic [EW-1:0]           w_head;
    logic [CH_W-1:0]         r_last_grant;

    logic [ADDR_WIDTH-1:0]   r_out_index;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [CH_W-1:0]         r_out_channel;
    logic [NUM_CHANNELS-1:0] r_overflow;

    // Occupancy status and push/drop decisions, all based on registered
    // occupancy so that a same-cycle pop never makes room for a push.
    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        w_push     = '0;
        w_drop     = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_nonempty[c] = (r_count[c] != '0);
            w_full[c]     = (r_count[c] == FULL_CNT);
            w_push[c]     = inValid[c] && !w_full[c] && !flush;
            w_drop[c]     = inValid[c] &&  w_full[c] && !flush;
        end
    end

    // The output stage can take a new packet when empty or when the held
    // packet is being accepted this cycle.
    assign w_free = (r_state == ST_EMPTY) || outReady;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int               v_idx;
        logic [CH_W-1:0]  v_ch;
        v_idx       = 0;
        v_ch        = '0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            v_idx = int'(r_last_grant) + k;
            v_idx = (v_idx >= NUM_CHANNELS) ? (v_idx - NUM_CHANNELS) : v_idx;
            v_ch  = CH_W'(v_idx);
            if (!w_grant_vld && w_nonempty[v_ch]) begin
                w_grant_vld = 1'b1;
                w_grant     = v_ch;
            end else begin
                w_grant_vld = w_grant_vld;
                w_grant     = w_grant;
            end
        end
    end

    // Pop the granted head only when the stage is free and no flush is active.
    always_comb begin
        w_pop = '0;
        if (w_free && w_grant_vld && !flush) begin
            w_pop[w_grant] = 1'b1;
        end else begin
            w_pop = '0;
        end
    end

    assign w_head = r_mem[w_grant][r_rd_ptr[w_grant]];

    // FIFO payload storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wr_ptr[c]] <= {inIndex[c*ADDR_WIDTH +: ADDR_WIDTH],
                                          inData[c*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // FIFO pointers and occupancy; flush empties every FIFO at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
        end else if (flush) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_push[c]) begin
                    r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_count[c] <= r_count[c] + 1'b1;
                    2'b01:   r_count[c] <= r_count[c] - 1'b1;
                    default: r_count[c] <= r_count[c];
                endcase
            end
        end
    end

    // Sticky drop flags; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= (clearOverflow ? {NUM_CHANNELS{1'b0}} : r_overflow) | w_drop;
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output stage next-state: flush wins, otherwise refill whenever free.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (!flush && w_grant_vld) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                end else if (outReady) begin
                    w_state_nxt = w_grant_vld ? ST_HOLD : ST_EMPTY;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output stage outputs decoded from the state register.
    always_comb begin
        w_out_valid = 1'b0;
        case (r_state)
            ST_EMPTY: w_out_valid = 1'b0;
            ST_HOLD:  w_out_valid = 1'b1;
            default:  w_out_valid = 1'b0;
        endcase
    end

    // Output payload registers load on every grant and otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_index   <= '0;
            r_out_data    <= '0;
            r_out_channel <= '0;
        end else if (|w_pop) begin
            r_out_index   <= w_head[EW-1 -: ADDR_WIDTH];
            r_out_data    <= w_head[DATA_WIDTH-1:0];
            r_out_channel <= w_grant;
        end
    end

    // Round-robin pointer; reset value gives channel 0 first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= LAST_CH;
        end else if (|w_pop) begin
            r_last_grant <= w_grant;
        end
    end

    assign outIndex   = r_out_index;
    assign outData    = r_out_data;
    assign outChannel = r_out_channel;
    assign outValid   = w_out_valid;
    assign overflow   = r_overflow;

endmodule
